online_mult_ctrl: RTL and testbench

ONLINE_MULT_CTRL -- requirements
Module: online_mult_ctrl

---
 rtl/online_mult_ctrl_pkg.sv | 29 ++
 rtl/online_mult_ctrl_step.sv | 28 ++
 rtl/online_mult_ctrl.sv | 100 ++++++++++
 tb/tb_online_mult_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/online_mult_ctrl_pkg.sv
// Shared bit representations for the online multiplier controller:
// radix-2 signed-digit codes and FSM state codes.
package online_mult_ctrl_pkg;

  localparam logic [1:0] R2_ZERO    = 2'b00;
  localparam logic [1:0] R2_POS_ONE = 2'b01;
  localparam logic [1:0] R2_NEG_ONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The unused code 2'b10 is mapped to ZERO so the datapath never sees it.
  function automatic logic [1:0] r2_sanitize(input logic [1:0] d);
    case (d)
      R2_ZERO, R2_POS_ONE, R2_NEG_ONE: r2_sanitize = d;
      default:                         r2_sanitize = R2_ZERO;
    endcase
  endfunction

  function automatic logic r2_is_illegal(input logic [1:0] d);
    return (r2_sanitize(d) != d);
  endfunction

endpackage

// File: rtl/online_mult_ctrl_step.sv
// step_counter: counts datapath step cycles, with synchronous clear,
// count enable and a terminal-count compare against a supplied value.
module step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_term
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + WIDTH'(1);
  end

  assign o_count   = r_count;
  assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/online_mult_ctrl.sv
// Control unit for an MSD-first radix-2 online multiplier: sequences
// clear, operand intake, DELTA flush steps and the result digit stream.
module online_mult_ctrl
  import online_mult_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELTA = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] x_digit,
  input  logic [1:0] y_digit,
  input  logic [1:0] dp_sel_digit,
  output logic       dp_step,
  output logic       dp_clr,
  output logic [1:0] dp_x_digit,
  output logic [1:0] dp_y_digit,
  output logic [1:0] z_digit,
  output logic       z_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int             CW        = $clog2(N + DELTA + 1);
  localparam logic [CW-1:0]  LAST_RUN  = CW'(N - 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(N + DELTA - 1);
  localparam logic [CW-1:0]  FIRST_Z   = CW'(DELTA);

  state_t        r_state;
  logic          r_err;
  logic          r_z_valid;
  logic [1:0]    r_z_digit;

  logic          w_accept;
  logic          w_step;
  logic          w_emit;
  logic          w_at_term;
  logic [CW-1:0] w_term;
  logic [CW-1:0] w_count;

  assign w_accept = (r_state == S_RUN) && in_valid;
  assign w_step   = w_accept || (r_state == S_FLUSH);
  assign w_term   = (r_state == S_FLUSH) ? LAST_STEP : LAST_RUN;
  // The first DELTA steps only prime the residual; digits appear after that.
  assign w_emit   = w_step && (w_count >= FIRST_Z);

  step_counter #(.WIDTH(CW)) u_step_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == S_CLEAR),
    .i_en      (w_step),
    .i_term    (w_term),
    .o_count   (w_count),
    .o_at_term (w_at_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_err     <= 1'b0;
      r_z_valid <= 1'b0;
      r_z_digit <= R2_ZERO;
    end else begin
      r_z_valid <= w_emit;
      r_z_digit <= w_emit ? dp_sel_digit : R2_ZERO;
      case (r_state)
        S_IDLE:  if (start) r_state <= S_CLEAR;
        S_CLEAR: begin
          r_err   <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: if (w_accept) begin
          if (r2_is_illegal(x_digit) || r2_is_illegal(y_digit)) r_err <= 1'b1;
          if (w_at_term) r_state <= S_FLUSH;
        end
        S_FLUSH: if (w_at_term) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: outputs are continuous decodes of registered state, so no
  // incomplete-assignment path exists that could infer a latch.
  assign in_ready   = (r_state == S_RUN);
  assign dp_step    = w_step;
  assign dp_clr     = (r_state == S_CLEAR);
  assign dp_x_digit = w_accept ? r2_sanitize(x_digit) : R2_ZERO;
  assign dp_y_digit = w_accept ? r2_sanitize(y_digit) : R2_ZERO;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign z_valid    = r_z_valid;
  assign z_digit    = r_z_digit;

endmodule

// File: tb/tb_online_mult_ctrl.sv
// Directed bench for online_mult_ctrl (N=8, DELTA=3): normal run, stall,
// illegal digit, start during RUN, and reset during FLUSH.
module tb_online_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] x_digit = 2'b00;
  logic [1:0] y_digit = 2'b00;
  logic [1:0] dp_sel_digit = 2'b00;
  logic       dp_step, dp_clr;
  logic [1:0] dp_x_digit, dp_y_digit, z_digit;
  logic       z_valid, busy, done, err;

  int checks = 0;
  int failures = 0;

  online_mult_ctrl #(.N(8), .DELTA(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_digit      (x_digit),
    .y_digit      (y_digit),
    .dp_sel_digit (dp_sel_digit),
    .dp_step      (dp_step),
    .dp_clr       (dp_clr),
    .dp_x_digit   (dp_x_digit),
    .dp_y_digit   (dp_y_digit),
    .z_digit      (z_digit),
    .z_valid      (z_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b0);
    check1({tag, "_dp_step"}, dp_step, 1'b0);
    check1({tag, "_dp_clr"}, dp_clr, 1'b0);
    check2({tag, "_dp_x"}, dp_x_digit, 2'b00);
    check2({tag, "_dp_y"}, dp_y_digit, 2'b00);
    check1({tag, "_z_valid"}, z_valid, 1'b0);
    check2({tag, "_z_digit"}, z_digit, 2'b00);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_err"}, err, 1'b0);
  endtask

  // One operation. t=0 is the CLEAR cycle. abort_t >= 0 pulls rst low in
  // that cycle and returns. Observed totals are compared with hand values.
  task automatic run_op(input string name, input bit stall, input int bad_pair,
                        input bit start_in_run, input int abort_t,
                        input int exp_done_t, input int exp_steps, input int exp_z);
    int sent = 0, flush_cnt = 0, stall_cnt = 0, k = 0;
    int obs_steps = 0, obs_z = 0, obs_done = 0, done_t = -1;
    logic exp_zv = 1'b0, exp_err = 1'b0;
    logic [1:0] exp_zd = 2'b00;
    logic [1:0] xs, xf;
    logic run_ph, flush_ph, done_ph, exp_step;

    tick();
    start = 1'b1;
    #1;
    check1({name, "_idle_busy"}, busy, 1'b0);
    check1({name, "_idle_ready"}, in_ready, 1'b0);
    tick();
    start = 1'b0;
    #1;
    check1({name, "_clr"}, dp_clr, 1'b1);
    check1({name, "_clr_busy"}, busy, 1'b1);
    check1({name, "_clr_step"}, dp_step, 1'b0);

    for (int t = 1; t <= 40; t++) begin
      tick();
      run_ph   = (sent < 8);
      flush_ph = (sent == 8) && (flush_cnt < 3);
      done_ph  = !run_ph && !flush_ph;
      if (run_ph && stall && sent == 4 && stall_cnt < 2) begin
        in_valid = 1'b0;
        stall_cnt++;
      end else begin
        in_valid = run_ph;
      end
      xs = (t % 2 == 1) ? 2'b01 : 2'b11;
      xf = xs;
      if (run_ph && sent == bad_pair - 1) begin
        xs = 2'b10;
        xf = 2'b00;
      end
      x_digit = xs;
      y_digit = (t % 3 == 0) ? 2'b00 : 2'b11;
      case (t % 3)
        0:       dp_sel_digit = 2'b01;
        1:       dp_sel_digit = 2'b11;
        default: dp_sel_digit = 2'b00;
      endcase
      start = start_in_run && (t >= 2) && (t <= 4);
      if (t == abort_t) begin
        rst = 1'b0;
        #1;
        check_reset_outputs({name, "_abort"});
        in_valid = 1'b0;
        return;
      end
      #1;
      exp_step = run_ph ? in_valid : flush_ph;
      check1($sformatf("%s_ready_t%0d", name, t), in_ready, run_ph);
      check1($sformatf("%s_step_t%0d", name, t), dp_step, exp_step);
      check2($sformatf("%s_dpx_t%0d", name, t), dp_x_digit, (run_ph && in_valid) ? xf : 2'b00);
      check2($sformatf("%s_dpy_t%0d", name, t), dp_y_digit, (run_ph && in_valid) ? y_digit : 2'b00);
      check1($sformatf("%s_zv_t%0d", name, t), z_valid, exp_zv);
      check2($sformatf("%s_zd_t%0d", name, t), z_digit, exp_zd);
      check1($sformatf("%s_done_t%0d", name, t), done, done_ph);
      check1($sformatf("%s_err_t%0d", name, t), err, exp_err);
      obs_steps += int'(dp_step);
      obs_z     += int'(z_valid);
      obs_done  += int'(done);
      exp_zv = exp_step && (k >= 3);
      exp_zd = exp_zv ? dp_sel_digit : 2'b00;
      if (exp_step) k++;
      if (run_ph && in_valid) begin
        if (xs == 2'b10) exp_err = 1'b1;
        sent++;
      end
      if (flush_ph) flush_cnt++;
      if (done_ph) begin
        done_t = t;
        break;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    checki({name, "_done_cycle"}, done_t, exp_done_t);
    checki({name, "_steps"}, obs_steps, exp_steps);
    checki({name, "_z_pulses"}, obs_z, exp_z);
    checki({name, "_done_pulses"}, obs_done, 1);
    tick();
    check1({name, "_after_busy"}, busy, 1'b0);
    check1({name, "_after_done"}, done, 1'b0);
    check1({name, "_after_err"}, err, exp_err);
  endtask

  initial begin
    int late_z, late_done;
    #3;
    check_reset_outputs("por");
    tick();
    tick();
    rst = 1'b1;

    run_op("basic",   1'b0, 0, 1'b0, -1, 12, 11, 8);
    run_op("stall",   1'b1, 0, 1'b0, -1, 14, 11, 8);
    run_op("illegal", 1'b0, 2, 1'b0, -1, 12, 11, 8);
    run_op("startrun", 1'b0, 0, 1'b1, -1, 12, 11, 8);
    run_op("rstflush", 1'b0, 0, 1'b0, 10, 0, 0, 0);

    late_z = 0;
    late_done = 0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      late_z    += int'(z_valid);
      late_done += int'(done) + int'(busy);
    end
    checki("abort_no_z", late_z, 0);
    checki("abort_no_done_busy", late_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
